// File: rtl/itr_pkg.sv
// Shared definitions for the interrupt entry/return sequencer.
// Latency: n/a (package only).
// Backpressure: n/a.
package itr_pkg;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_FLAG_W      = 2;
  localparam int DEF_TO_W        = 8;
  localparam int DEF_ISR_TIMEOUT = 200;

  // Sequencer states, 3-bit encoding.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SAVE    = 3'd1,
    S_VECTOR  = 3'd2,
    S_ACK     = 3'd3,
    S_SERVICE = 3'd4,
    S_RESTORE = 3'd5
  } state_t;

endpackage

// File: rtl/isr_shadow_reg.sv
// Shadow register holding the interrupted PC/ACC/flags context (one level).
// Latency: d captured on the clock edge where load=1; q valid the next cycle.
// Backpressure: none; load is a plain enable.
// Ports: clk, clr (async active-high), load, d (context in), q (saved context).
module isr_shadow_reg
  import itr_pkg::*;
#(
  parameter int W = DEF_ADDR_W + DEF_DATA_W + DEF_FLAG_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/itr_sequencer.sv
// CPU-side interrupt responder: save context, vector to ISR, ack, watchdog, restore on RTI.
// Latency: trigger edge -> 3 stalled cycles (SAVE, VECTOR, ACK) -> SERVICE; RESTORE is 1 cycle.
// Backpressure: controller enable (itr_en) is dropped outside IDLE; pending requests wait there.
// Ports: controller side i_pending/isr_vec/itr_en/itr_clr; CPU side instr_boundary, pc_in,
//        acc_in, flags_in, rti/ei/di pulses, cpu_stall, pc_load(+val), ctx_load(+acc/flags);
//        status in_isr, isr_fault (sticky), bad_rti (pulse).
module itr_sequencer
  import itr_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int FLAG_W      = DEF_FLAG_W,
  parameter int TO_W        = DEF_TO_W,
  parameter int ISR_TIMEOUT = DEF_ISR_TIMEOUT,
  parameter bit GIE_RESET   = 1'b1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              i_pending,
  input  logic [ADDR_W-1:0] isr_vec,
  input  logic              instr_boundary,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] acc_in,
  input  logic [FLAG_W-1:0] flags_in,
  input  logic              rti,
  input  logic              ei,
  input  logic              di,
  output logic              itr_en,
  output logic              itr_clr,
  output logic              cpu_stall,
  output logic              pc_load,
  output logic [ADDR_W-1:0] pc_load_val,
  output logic              ctx_load,
  output logic [DATA_W-1:0] acc_out,
  output logic [FLAG_W-1:0] flags_out,
  output logic              in_isr,
  output logic              isr_fault,
  output logic              bad_rti
);

  localparam int CTX_W = ADDR_W + DATA_W + FLAG_W;
  // Watchdog value seen on the last permitted SERVICE cycle.
  localparam logic [TO_W-1:0] WD_LAST = TO_W'(ISR_TIMEOUT - 1);

  state_t state, state_nxt;

  logic              gie;
  logic [ADDR_W-1:0] vec_q;
  logic [TO_W-1:0]   wd;
  logic              fault_q;
  logic              take;
  logic              wd_expire;
  logic [CTX_W-1:0]  ctx_q;
  logic [ADDR_W-1:0] shadow_pc;
  logic [DATA_W-1:0] shadow_acc;
  logic [FLAG_W-1:0] shadow_flags;

  assign itr_en    = gie && (state == S_IDLE);
  assign take      = i_pending && itr_en && instr_boundary;
  // An rti arriving on the expiry cycle wins: normal return, no fault.
  assign wd_expire = (state == S_SERVICE) && (wd == WD_LAST) && !rti;
  assign isr_fault = fault_q;
  // Keep outputs quiet for the whole time clr is held, not just after the flops settle.
  assign bad_rti   = rti && (state != S_SERVICE) && !clr;

  isr_shadow_reg #(.W(CTX_W)) u_shadow (
    .clk  (clk),
    .clr  (clr),
    .load (take),
    .d    ({pc_in, acc_in, flags_in}),
    .q    (ctx_q)
  );

  assign {shadow_pc, shadow_acc, shadow_flags} = ctx_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      gie     <= GIE_RESET;
      vec_q   <= '0;
      wd      <= '0;
      fault_q <= 1'b0;
    end else begin
      // di dominates a simultaneous ei.
      if (di) begin
        gie <= 1'b0;
      end else if (ei) begin
        gie <= 1'b1;
      end

      if (take) begin
        vec_q <= isr_vec;
      end

      if (state == S_ACK) begin
        wd <= '0;
      end else if ((state == S_SERVICE) && (wd != '1)) begin
        wd <= wd + 1'b1;
      end

      if (wd_expire) begin
        fault_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    cpu_stall   = 1'b0;
    pc_load     = 1'b0;
    pc_load_val = '0;
    itr_clr     = 1'b0;
    ctx_load    = 1'b0;
    acc_out     = '0;
    flags_out   = '0;
    in_isr      = 1'b0;

    case (state)
      S_IDLE: begin
        if (take) begin
          state_nxt = S_SAVE;
        end
      end
      S_SAVE: begin
        cpu_stall = 1'b1;
        state_nxt = S_VECTOR;
      end
      S_VECTOR: begin
        cpu_stall   = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = vec_q;
        state_nxt   = S_ACK;
      end
      S_ACK: begin
        cpu_stall = 1'b1;
        itr_clr   = 1'b1;
        state_nxt = S_SERVICE;
      end
      S_SERVICE: begin
        in_isr = 1'b1;
        if (rti || wd_expire) begin
          state_nxt = S_RESTORE;
        end
      end
      S_RESTORE: begin
        cpu_stall   = 1'b1;
        pc_load     = 1'b1;
        pc_load_val = shadow_pc;
        ctx_load    = 1'b1;
        acc_out     = shadow_acc;
        flags_out   = shadow_flags;
        state_nxt   = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_itr_sequencer.sv
// Randomized + directed bench for itr_sequencer with a timeline-based reference model.
// Latency: one expected record per clock cycle, compared at the falling edge.
// Backpressure: n/a.
module tb_itr_sequencer;

  localparam int TIMEOUT = 200;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       i_pending = 1'b0;
  logic [7:0] isr_vec = '0;
  logic       instr_boundary = 1'b0;
  logic [7:0] pc_in = '0;
  logic [7:0] acc_in = '0;
  logic [1:0] flags_in = '0;
  logic       rti = 1'b0;
  logic       ei = 1'b0;
  logic       di = 1'b0;
  logic       itr_en, itr_clr, cpu_stall, pc_load, ctx_load, in_isr, isr_fault, bad_rti;
  logic [7:0] pc_load_val, acc_out;
  logic [1:0] flags_out;

  itr_sequencer #(
    .ADDR_W(8), .DATA_W(8), .FLAG_W(2), .TO_W(8), .ISR_TIMEOUT(TIMEOUT), .GIE_RESET(1'b1)
  ) dut (
    .clk(clk), .clr(clr), .i_pending(i_pending), .isr_vec(isr_vec),
    .instr_boundary(instr_boundary), .pc_in(pc_in), .acc_in(acc_in), .flags_in(flags_in),
    .rti(rti), .ei(ei), .di(di), .itr_en(itr_en), .itr_clr(itr_clr), .cpu_stall(cpu_stall),
    .pc_load(pc_load), .pc_load_val(pc_load_val), .ctx_load(ctx_load), .acc_out(acc_out),
    .flags_out(flags_out), .in_isr(in_isr), .isr_fault(isr_fault), .bad_rti(bad_rti)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit clr; bit mid_clr; bit pend; logic [7:0] vec; bit ib;
    logic [7:0] pc; logic [7:0] acc; logic [1:0] fl; bit rti; bit ei; bit di;
  } stim_t;

  typedef struct {
    bit itr_en; bit itr_clr; bit stall; bit pc_load; logic [7:0] pc_val;
    bit ctx_load; logic [7:0] acc; logic [1:0] fl; bit in_isr; bit fault; bit bad_rti;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: "busy" covers entry + service, age counts cycles since the
  // trigger edge (1..3 are the stalled entry cycles, 4+ is service), "rest" marks
  // the single restore cycle.
  bit         m_gie, m_busy, m_rest, m_fault;
  int         m_age;
  logic [7:0] m_pc, m_acc, m_vec;
  logic [1:0] m_fl;

  task automatic model_reset();
    m_gie = 1'b1; m_busy = 1'b0; m_rest = 1'b0; m_fault = 1'b0; m_age = 0;
    m_pc = '0; m_acc = '0; m_vec = '0; m_fl = '0;
  endtask

  function automatic exp_t model_out(input stim_t s, input bit rst_now);
    exp_t e;
    bit svc, vecc;
    svc        = m_busy && (m_age >= 4);
    vecc       = m_busy && (m_age == 2);
    e.itr_en   = m_gie && !m_busy && !m_rest;
    e.itr_clr  = m_busy && (m_age == 3);
    e.stall    = (m_busy && (m_age < 4)) || m_rest;
    e.pc_load  = vecc || m_rest;
    e.pc_val   = vecc ? m_vec : (m_rest ? m_pc : 8'h00);
    e.ctx_load = m_rest;
    e.acc      = m_rest ? m_acc : 8'h00;
    e.fl       = m_rest ? m_fl : 2'b00;
    e.in_isr   = svc;
    e.fault    = m_fault;
    e.bad_rti  = s.rti && !svc && !rst_now;
    return e;
  endfunction

  task automatic model_update(input stim_t s);
    bit en;
    en = m_gie && !m_busy && !m_rest;
    if (m_rest) begin
      m_rest = 1'b0;
    end else if (!m_busy) begin
      if (s.pend && en && s.ib) begin
        m_busy = 1'b1; m_age = 1;
        m_pc = s.pc; m_acc = s.acc; m_fl = s.fl; m_vec = s.vec;
      end
    end else if (m_age < 4) begin
      m_age++;
    end else if (s.rti) begin
      m_busy = 1'b0; m_rest = 1'b1;
    end else if (m_age - 4 == TIMEOUT - 1) begin
      m_busy = 1'b0; m_rest = 1'b1; m_fault = 1'b1;
    end else begin
      m_age++;
    end
    if (s.di) m_gie = 1'b0;
    else if (s.ei) m_gie = 1'b1;
  endtask

  function automatic stim_t blank();
    stim_t s;
    s.clr = 0; s.mid_clr = 0; s.pend = 0; s.ib = 0; s.rti = 0; s.ei = 0; s.di = 0;
    s.vec = 8'($urandom); s.pc = 8'($urandom); s.acc = 8'($urandom); s.fl = 2'($urandom);
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s      = blank();
    s.pend = ($urandom_range(0, 1) == 1);
    s.ib   = ($urandom_range(0, 3) != 0);
    s.rti  = ($urandom_range(0, 7) == 0);
    s.ei   = ($urandom_range(0, 11) == 0);
    s.di   = ($urandom_range(0, 15) == 0);
    return s;
  endfunction

  // Drive one cycle shortly after the rising edge and queue what the DUT must show.
  task automatic step(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    i_pending = s.pend; isr_vec = s.vec; instr_boundary = s.ib;
    pc_in = s.pc; acc_in = s.acc; flags_in = s.fl;
    rti = s.rti; ei = s.ei; di = s.di;
    clr = s.clr;
    if (s.mid_clr) begin
      #2;
      clr = 1'b1;
    end
    if (clr) model_reset();
    e = model_out(s, clr);
    exp_q.push_back(e);
    if (!clr) model_update(s);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h required %0h", name, $time, act, req);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("itr_en",      32'(itr_en),      32'(e.itr_en));
        chk("itr_clr",     32'(itr_clr),     32'(e.itr_clr));
        chk("cpu_stall",   32'(cpu_stall),   32'(e.stall));
        chk("pc_load",     32'(pc_load),     32'(e.pc_load));
        chk("pc_load_val", 32'(pc_load_val), 32'(e.pc_val));
        chk("ctx_load",    32'(ctx_load),    32'(e.ctx_load));
        chk("acc_out",     32'(acc_out),     32'(e.acc));
        chk("flags_out",   32'(flags_out),   32'(e.fl));
        chk("in_isr",      32'(in_isr),      32'(e.in_isr));
        chk("isr_fault",   32'(isr_fault),   32'(e.fault));
        chk("bad_rti",     32'(bad_rti),     32'(e.bad_rti));
      end
    end
  end

  initial begin : watchdog_limit
    #400000;
    $display("FAIL sim_time_limit: bench did not finish in time");
    $fatal(1, "time limit");
  end

  initial begin : stimulus
    stim_t s;
    model_reset();

    // Reset held, then released.
    s = blank(); s.clr = 1; step(s); step(s);
    s = blank(); step(s);

    // Basic entry and return.
    s = blank(); s.pend = 1; s.ib = 1;
    s.pc = 8'h20; s.acc = 8'h5A; s.fl = 2'b01; s.vec = 8'h96;
    step(s);
    s = blank(); repeat (6) step(s);
    s = blank(); s.rti = 1; step(s);
    s = blank(); repeat (3) step(s);

    // Gating: no boundary, then di+ei together (di wins), then boundary with gie off.
    s = blank(); s.pend = 1; repeat (10) step(s);
    s.di = 1; s.ei = 1; step(s);
    s.di = 0; s.ei = 0; s.ib = 1; repeat (4) step(s);
    s = blank(); s.ei = 1; step(s);
    s = blank(); step(s);

    // Stray rti in IDLE.
    s = blank(); s.rti = 1; step(s);
    s = blank(); step(s);

    // Back-to-back: pending held through RESTORE.
    s = blank(); s.pend = 1; s.ib = 1; s.pc = 8'h50; s.acc = 8'h0F; s.fl = 2'b10; s.vec = 8'h40;
    step(s);
    s.pc = 8'h77; s.acc = 8'hC3; s.fl = 2'b11; s.vec = 8'hE1;
    repeat (5) step(s);
    s.rti = 1; step(s);
    s.rti = 0; repeat (7) step(s);
    s = blank(); s.rti = 1; step(s);
    s = blank(); repeat (3) step(s);

    // rti on the expiry cycle: normal return, no fault.
    s = blank(); s.pend = 1; s.ib = 1; step(s);
    s = blank(); repeat (3 + TIMEOUT - 1) step(s);
    s.rti = 1; step(s);
    s = blank(); repeat (3) step(s);

    // Watchdog expiry with rti withheld; fault then stays set across a normal ISR.
    s = blank(); s.pend = 1; s.ib = 1; step(s);
    s = blank(); repeat (3 + TIMEOUT + 4) step(s);
    s = blank(); s.pend = 1; s.ib = 1; step(s);
    s = blank(); repeat (5) step(s);
    s.rti = 1; step(s);
    s = blank(); repeat (2) step(s);

    // Reset asserted mid-VECTOR.
    s = blank(); s.pend = 1; s.ib = 1; step(s);
    s = blank(); step(s);
    s = blank(); s.mid_clr = 1; step(s);
    s = blank(); s.clr = 1; step(s);
    s = blank(); repeat (2) step(s);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      s = rand_stim();
      step(s);
    end
    s = blank(); repeat (3) step(s);

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: %0d records left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
